// File: rtl/lz77_pkg.sv
// Shared LZ77 constants and the decoder state type.
// The encoder imports the same history depth and end-of-string marker.
package lz77_pkg;

    localparam int unsigned SB_DEPTH = 9;
    localparam logic [7:0]  EOS_CHAR = 8'h45;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        LIT  = 2'd2
    } dec_state_t;

    function automatic logic is_eos(input logic [7:0] chr);
        return (chr == EOS_CHAR);
    endfunction

endpackage

// File: rtl/lz77_decoder_if.sv
// Code-triple input and decoded-character output bundle of the LZ77 decoder.
interface lz77_decoder_if;

    logic       code_valid;
    logic [3:0] code_pos;
    logic [3:0] code_len;
    logic [7:0] chardata;
    logic       busy;
    logic       valid;
    logic [7:0] char_nxt;
    logic       finish;

    modport master (
        output code_valid, code_pos, code_len, chardata,
        input  busy, valid, char_nxt, finish
    );

    modport slave (
        input  code_valid, code_pos, code_len, chardata,
        output busy, valid, char_nxt, finish
    );

endinterface

// File: rtl/lz77_search_buf.sv
// History shift register: newest char at index 0, indexed read returns 8'h00
// for any index past the end, synchronous clear has priority over shifting.
module lz77_search_buf
    import lz77_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic       clk,
    input  logic       clr_i,
    input  logic       shift_i,
    input  logic [7:0] din_i,
    input  logic [3:0] rd_idx_i,
    output logic [7:0] rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    // History storage: clear, or push a new char at the front
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (shift_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i];
            end
        end
    end

    // Read mux; an index with no matching entry yields zero rather than X
    always_comb begin
        rd_data_o = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            rd_data_o = (rd_idx_i == 4'(i)) ? mem_q[i] : rd_data_o;
        end
    end

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 decoder: expands (offset, length, literal) triples into one char per cycle,
// clearing the history when the literal is the end-of-string marker.
module lz77_decoder
    import lz77_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    lz77_decoder_if.slave bus
);

    dec_state_t state_q, state_d;
    logic [3:0] pos_q, pos_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] chr_q, chr_d;
    logic [7:0] char_q, char_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;
    logic       finish_q, finish_d;

    logic       accept_s;
    logic       shift_s;
    logic       clr_s;
    logic [7:0] shift_data_s;
    logic [7:0] rd_data_s;

    assign accept_s = bus.code_valid && !busy_q;

    lz77_search_buf #(
        .DEPTH (SB_DEPTH)
    ) u_hist (
        .clk       (clk),
        .clr_i     (reset || clr_s),
        .shift_i   (shift_s),
        .din_i     (shift_data_s),
        .rd_idx_i  (pos_q),
        .rd_data_o (rd_data_s)
    );

    // Next-state and output logic of the decode FSM
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        cnt_d        = cnt_q;
        chr_d        = chr_q;
        char_d       = char_q;
        busy_d       = busy_q;
        valid_d      = 1'b0;
        finish_d     = 1'b0;
        shift_s      = 1'b0;
        clr_s        = 1'b0;
        shift_data_s = 8'h00;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    pos_d  = bus.code_pos;
                    chr_d  = bus.chardata;
                    cnt_d  = bus.code_len;
                    busy_d = 1'b1;
                    if (bus.code_len != 4'd0) begin
                        state_d = COPY;
                    end else begin
                        state_d = LIT;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            COPY: begin
                // Reading a fixed offset of a shifting history replicates overlapping runs
                char_d       = rd_data_s;
                valid_d      = 1'b1;
                shift_s      = 1'b1;
                shift_data_s = rd_data_s;
                cnt_d        = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = LIT;
                end else begin
                    state_d = COPY;
                end
            end
            LIT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (is_eos(chr_q)) begin
                    finish_d = 1'b1;
                    clr_s    = 1'b1;
                end else begin
                    char_d       = chr_q;
                    valid_d      = 1'b1;
                    shift_s      = 1'b1;
                    shift_data_s = chr_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, latched triple and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pos_q    <= 4'd0;
            cnt_q    <= 4'd0;
            chr_q    <= 8'h00;
            char_q   <= 8'h00;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            chr_q    <= chr_d;
            char_q   <= char_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            finish_q <= finish_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.char_nxt = char_q;
    assign bus.finish   = finish_q;

endmodule

// File: tb/tb_lz77_decoder.sv
// Self-checking bench for lz77_decoder: directed scenarios plus random triples
// compared cycle by cycle against a queue-based LZ77 history model.
module tb_lz77_decoder;
    import lz77_pkg::*;

    logic clk;
    logic reset;
    lz77_decoder_if dif ();

    int vectors;
    int miscompares;
    logic [7:0] hist [$];

    lz77_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one triple at the current negedge and check every following cycle.
    task automatic run_triple(input logic [3:0] p, input logic [3:0] l, input logic [7:0] c,
                              input bit junk, input string tag);
        logic [7:0] exp_q [$];
        logic [7:0] b;
        logic e_b, e_v, e_f;
        logic [7:0] e_c;
        bit eos;
        dif.code_valid = 1'b1;
        dif.code_pos   = p;
        dif.code_len   = l;
        dif.chardata   = c;
        @(posedge clk);
        #1;
        if (junk) begin
            dif.code_valid = 1'b1;
            dif.code_pos   = 4'($urandom);
            dif.code_len   = 4'($urandom);
            dif.chardata   = 8'($urandom);
        end else begin
            dif.code_valid = 1'b0;
        end
        for (int k = 0; k < int'(l); k++) begin
            b = (int'(p) < hist.size()) ? hist[p] : 8'h00;
            exp_q.push_back(b);
            hist.push_front(b);
            if (hist.size() > SB_DEPTH) void'(hist.pop_back());
        end
        eos = (c == EOS_CHAR);
        if (eos) begin
            hist.delete();
        end else begin
            hist.push_front(c);
            if (hist.size() > SB_DEPTH) void'(hist.pop_back());
        end
        @(negedge clk);
        vectors++;
        if ({dif.busy, dif.valid, dif.finish} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s accept: busy/valid/finish got %b expected 100", tag,
                     {dif.busy, dif.valid, dif.finish});
        end
        for (int k = 0; k <= int'(l); k++) begin
            @(negedge clk);
            if (k < int'(l)) begin
                e_b = 1'b1; e_v = 1'b1; e_f = 1'b0; e_c = exp_q[k];
            end else if (eos) begin
                e_b = 1'b0; e_v = 1'b0; e_f = 1'b1; e_c = 8'h00;
            end else begin
                e_b = 1'b0; e_v = 1'b1; e_f = 1'b0; e_c = c;
            end
            vectors++;
            if ({dif.busy, dif.valid, dif.finish} !== {e_b, e_v, e_f} ||
                (e_v && dif.char_nxt !== e_c)) begin
                miscompares++;
                $display("FAIL %s out%0d: busy/valid/finish/char got %b/%h expected %b/%h",
                         tag, k, {dif.busy, dif.valid, dif.finish}, dif.char_nxt,
                         {e_b, e_v, e_f}, e_c);
            end
        end
        dif.code_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dif.code_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({dif.busy, dif.valid, dif.finish, dif.char_nxt} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_state: got %b/%h expected 000/00",
                     {dif.busy, dif.valid, dif.finish}, dif.char_nxt);
        end
        reset = 1'b0;
        hist.delete();
        run_triple(4'd0, 4'd2, 8'h78, 1'b0, "first_x");
    endtask

    task automatic test_literals();
        run_triple(4'd0, 4'd0, 8'h61, 1'b0, "lit_a");
        run_triple(4'd0, 4'd0, 8'h62, 1'b0, "lit_b");
        run_triple(4'd0, 4'd0, 8'h63, 1'b0, "lit_c");
    endtask

    task automatic test_copy();
        run_triple(4'd2, 4'd3, 8'h64, 1'b0, "copy_abcd");
    endtask

    task automatic test_overlap();
        run_triple(4'd0, 4'd0, 8'h61, 1'b0, "ovl_a");
        run_triple(4'd0, 4'd4, 8'h62, 1'b1, "ovl_aaaab");
        @(negedge clk);
        vectors++;
        if ({dif.busy, dif.valid, dif.finish} !== 3'b000) begin
            miscompares++;
            $display("FAIL ovl_ignored: busy/valid/finish got %b expected 000",
                     {dif.busy, dif.valid, dif.finish});
        end
    endtask

    task automatic test_eos();
        run_triple(4'd0, 4'd0, 8'h61, 1'b0, "eos_a");
        run_triple(4'd0, 4'd0, 8'h62, 1'b0, "eos_b");
        run_triple(4'd1, 4'd1, EOS_CHAR, 1'b0, "eos_term");
        run_triple(4'd0, 4'd1, 8'h7a, 1'b0, "eos_cleared");
    endtask

    task automatic test_mid_reset();
        dif.code_valid = 1'b1;
        dif.code_pos   = 4'd0;
        dif.code_len   = 4'd8;
        dif.chardata   = 8'h71;
        @(posedge clk);
        #1;
        dif.code_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({dif.busy, dif.valid, dif.finish, dif.char_nxt} !== 11'h000) begin
            miscompares++;
            $display("FAIL mid_reset: got %b/%h expected 000/00",
                     {dif.busy, dif.valid, dif.finish}, dif.char_nxt);
        end
        reset = 1'b0;
        hist.delete();
        run_triple(4'd0, 4'd1, 8'h6b, 1'b0, "after_reset");
    endtask

    task automatic test_boundaries();
        run_triple(4'd0, 4'd0, 8'h31, 1'b0, "bnd_fill");
        run_triple(4'd12, 4'd2, 8'h32, 1'b0, "bnd_pos_oor");
        run_triple(4'd8, 4'd15, 8'h33, 1'b0, "bnd_len15");
        run_triple(4'd3, 4'd5, EOS_CHAR, 1'b0, "bnd_eos_len");
    endtask

    task automatic test_random();
        logic [7:0] c;
        int gap;
        for (int n = 0; n < 40; n++) begin
            c = 8'($urandom_range(0, 255));
            if (c == EOS_CHAR) c = 8'h46;
            if ($urandom_range(0, 7) == 0) c = EOS_CHAR;
            run_triple(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), c,
                       bit'($urandom_range(0, 1)), "rand");
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                vectors++;
                if ({dif.busy, dif.valid, dif.finish} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL rand_idle: busy/valid/finish got %b expected 000",
                             {dif.busy, dif.valid, dif.finish});
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        dif.code_valid = 1'b0;
        dif.code_pos   = 4'd0;
        dif.code_len   = 4'd0;
        dif.chardata   = 8'h00;
        reset = 1'b1;
        test_reset();
        test_literals();
        test_copy();
        test_overlap();
        test_eos();
        test_mid_reset();
        test_boundaries();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
